sram_block_pipe: RTL

- Parametrised successor to the single-port multi-brick SRAM block. It replaces raw one-hot wordline and brick-enable inputs with a binary-addressed write port and a read port.
- The read port uses a valid/ready request handshake and returns registered read data through a 2-entry output buffer with its own valid/ready handshake.
- It sits between the SpMV merge datapath and the brick storage, so the merge core can tolerate consumer backpressure without losing read data.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/lim_brick_mem.sv | 39 +++
 rtl/sram_block_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared brick defaults, word/address typedefs and the parity helper used by sram_block_pipe.
`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 32
`endif
`ifndef LIM_BRICK_WORD_NUM
`define LIM_BRICK_WORD_NUM 16
`endif

package sram_pkg;
    localparam int LIM_BL_WIDTH   = `LIM_BRICK_WORD_SIZE;
    localparam int LIM_WL_WIDTH   = `LIM_BRICK_WORD_NUM;
    localparam int LIM_NUM_BRICKS = 4;
    localparam int LIM_DEPTH      = LIM_NUM_BRICKS * LIM_WL_WIDTH;
    localparam int LIM_ADDR_W     = (LIM_DEPTH > 1) ? $clog2(LIM_DEPTH) : 1;

    // Callers zero-extend their word into this fixed width before asking for parity.
    localparam int PARITY_MAX_W = 256;

    typedef logic [LIM_BL_WIDTH-1:0] word_t;
    typedef logic [LIM_ADDR_W-1:0]   addr_t;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/lim_brick_mem.sv
// One SRAM brick: one-hot wordline write, combinational one-hot read with write-first bypass.
module lim_brick_mem
    import sram_pkg::*;
#(
    parameter int WIDTH    = LIM_BL_WIDTH,
    parameter int WL_WIDTH = LIM_WL_WIDTH
) (
    input  logic                clk,
    input  logic                we,
    input  logic [WL_WIDTH-1:0] wr_wl,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [WL_WIDTH-1:0] rd_wl,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem_q [WL_WIDTH];

    always_ff @(posedge clk) begin
        for (int w = 0; w < WL_WIDTH; w++) begin
            if (we && wr_wl[w]) begin
                mem_q[w] <= wdata;
            end
        end
    end

    // A write landing on the wordline being read wins over the stored word.
    always_comb begin
        rdata = '0;
        for (int w = 0; w < WL_WIDTH; w++) begin
            if (rd_wl[w]) begin
                rdata = rdata | mem_q[w];
            end
        end
        if (we && ((wr_wl & rd_wl) != '0)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/sram_block_pipe.sv
// Binary-addressed multi-brick SRAM with a handshaked read port and a 2-entry output FIFO.
// Define SRAM_BLOCK_PIPE_PARITY_EN to store an even-parity bit per word and expose RDATA_PERR.
module sram_block_pipe
    import sram_pkg::*;
#(
    parameter int  NUM_BRICKS = LIM_NUM_BRICKS,
    parameter int  BL_WIDTH   = LIM_BL_WIDTH,
    parameter int  WL_WIDTH   = LIM_WL_WIDTH,
    localparam int DEPTH      = NUM_BRICKS * WL_WIDTH,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WR_EN,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [BL_WIDTH-1:0] WR_DATA,
    input  logic                RD_VALID,
    output logic                RD_READY,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    output logic                RDATA_VALID,
    input  logic                RDATA_READY,
`ifdef SRAM_BLOCK_PIPE_PARITY_EN
    output logic                RDATA_PERR,
`endif
    output logic [BL_WIDTH-1:0] RDATA
);

`ifdef SRAM_BLOCK_PIPE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int STORE_W = BL_WIDTH + PAR_W;

    int                  wr_brick, wr_word, rd_brick, rd_word;
    logic                wr_in_range, rd_in_range;
    logic [NUM_BRICKS-1:0] brick_we;
    logic [WL_WIDTH-1:0] wr_wl, rd_wl;
    logic [STORE_W-1:0]  wr_store, rd_store, rd_entry;
    logic [STORE_W-1:0]  brick_rdata [NUM_BRICKS];

    // Out-of-range addresses match no brick, so writes vanish and reads mux to zero.
    always_comb begin
        wr_brick    = int'(WR_ADDR) / WL_WIDTH;
        wr_word     = int'(WR_ADDR) % WL_WIDTH;
        rd_brick    = int'(RD_ADDR) / WL_WIDTH;
        rd_word     = int'(RD_ADDR) % WL_WIDTH;
        wr_in_range = int'(WR_ADDR) < DEPTH;
        rd_in_range = int'(RD_ADDR) < DEPTH;
        brick_we    = '0;
        wr_wl       = '0;
        rd_wl       = '0;
        for (int b = 0; b < NUM_BRICKS; b++) begin
            brick_we[b] = WR_EN && wr_in_range && (wr_brick == b);
        end
        for (int w = 0; w < WL_WIDTH; w++) begin
            wr_wl[w] = (wr_word == w);
            rd_wl[w] = (rd_word == w);
        end
    end

`ifdef SRAM_BLOCK_PIPE_PARITY_EN
    logic [PARITY_MAX_W-1:0] wr_ext, rd_ext;
    logic                    rd_perr;

    always_comb begin
        wr_ext                 = '0;
        wr_ext[BL_WIDTH-1:0]   = WR_DATA;
        rd_ext                 = '0;
        rd_ext[BL_WIDTH-1:0]   = rd_store[BL_WIDTH-1:0];
        wr_store               = {even_parity(wr_ext), WR_DATA};
        rd_perr                = rd_in_range && (rd_store[BL_WIDTH] != even_parity(rd_ext));
        rd_entry               = {rd_perr, rd_store[BL_WIDTH-1:0]};
    end
`else
    always_comb begin
        wr_store = WR_DATA;
        rd_entry = rd_store;
    end
`endif

    for (genvar b = 0; b < NUM_BRICKS; b++) begin : g_brick
        lim_brick_mem #(
            .WIDTH   (STORE_W),
            .WL_WIDTH(WL_WIDTH)
        ) u_brick (
            .clk  (CLK),
            .we   (brick_we[b]),
            .wr_wl(wr_wl),
            .wdata(wr_store),
            .rd_wl(rd_wl),
            .rdata(brick_rdata[b])
        );
    end

    always_comb begin
        rd_store = '0;
        for (int b = 0; b < NUM_BRICKS; b++) begin
            if (rd_in_range && (rd_brick == b)) begin
                rd_store = brick_rdata[b];
            end
        end
    end

    logic [STORE_W-1:0] fifo_q [2];
    logic [STORE_W-1:0] fifo_d [2];
    logic [STORE_W-1:0] head;
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push, pop;

    // Ready depends only on the registered count, so backpressure never reaches the request side combinationally.
    assign RD_READY    = (count_q != 2'd2);
    assign RDATA_VALID = (count_q != 2'd0);

    always_comb begin
        push     = RD_VALID && RD_READY;
        pop      = RDATA_VALID && RDATA_READY;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = rd_entry;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head  = fifo_q[rd_ptr_q];
    assign RDATA = head[BL_WIDTH-1:0];
`ifdef SRAM_BLOCK_PIPE_PARITY_EN
    assign RDATA_PERR = head[BL_WIDTH];
`endif

endmodule
